txt_attr_renderer: RTL and testbench

- Parametrised successor to the monochrome 8-pixel text renderer: converts pixel coordinates from the VGA timing generator into 12-bit RGB text-mode pixels.
- Reads a 16-bit character/attribute word from display memory, then a glyph row from font memory. Supports per-cell foreground/background colour, attribute blink and a blinking block-underline cursor.
- Fixed 4-cycle pipeline; sync and data-enable are delayed to stay aligned with pixel data.
- Sits between the VGA timing module and the DAC/pin output stage.

---
 rtl/txt_pkg.sv | 33 +++
 rtl/txt_palette.sv | 24 ++
 rtl/txt_attr_renderer.sv | 173 +++++++++++++++++
 tb/tb_txt_attr_renderer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/txt_pkg.sv
// Shared constants and types for the attribute-capable text renderer.
// Attribute word layout, palette levels and pipeline depth live here.
package txt_pkg;

   localparam int LATENCY  = 4;
   localparam int GLYPH_W  = 8;
   localparam int CHAR_W   = 8;
   localparam int CURSOR_H = 2;

   localparam int CHAR_LSB = 0;
   localparam int CHAR_MSB = 7;
   localparam int ATTR_LSB = 8;
   localparam int ATTR_MSB = 15;

   localparam logic [3:0]  CH_BASE    = 4'hA;
   localparam logic [3:0]  CH_BRIGHT  = 4'h5;
   localparam logic [3:0]  IRGB_BROWN = 4'b0110;
   localparam logic [11:0] RGB_BROWN  = 12'hA50;

   // Bit order mirrors dis_data[15:8] so a plain cast unpacks the attribute byte.
   typedef struct packed {
      logic       blink;
      logic [2:0] bg;
      logic [3:0] fg;
   } attr_t;

   typedef struct packed {
      logic vs;
      logic hs;
      logic de;
   } sync_t;

endpackage

// File: rtl/txt_palette.sv
// IRGB to RGB444 colour lookup; intensity lifts every channel by one step,
// and dark yellow is remapped to brown.
module txt_palette
   import txt_pkg::*;
(
   input  logic [3:0]  irgb,
   output logic [11:0] rgb
);

   logic [3:0] off_lvl;
   logic [3:0] on_lvl;

   always_comb begin
      off_lvl = irgb[3] ? CH_BRIGHT : 4'h0;
      on_lvl  = off_lvl + CH_BASE;
      rgb     = {irgb[2] ? on_lvl : off_lvl,
                 irgb[1] ? on_lvl : off_lvl,
                 irgb[0] ? on_lvl : off_lvl};
      if (irgb == IRGB_BROWN) begin
         rgb = RGB_BROWN;
      end
   end

endmodule

// File: rtl/txt_attr_renderer.sv
// Text-mode pixel renderer: display memory -> font memory -> coloured RGB444,
// with blink attribute and block-underline cursor, fixed 4-clock latency.
module txt_attr_renderer
   import txt_pkg::*;
#(
   parameter int COLS         = 80,
   parameter int ROWS         = 30,
   parameter int FONT_H       = 16,
   parameter int COORD_W      = 10,
   parameter int ADDR_W       = 12,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                             clk,
   input  logic                             clr,
   input  logic [COORD_W-1:0]               pix_x,
   input  logic [COORD_W-1:0]               pix_y,
   input  logic                             de_in,
   input  logic                             hs_in,
   input  logic                             vs_in,
   input  logic                             frame_start,
   input  logic                             cursor_en,
   input  logic [6:0]                       cursor_col,
   input  logic [4:0]                       cursor_row,
   output logic [ADDR_W-1:0]                dis_addr,
   output logic                             dis_mem_en,
   input  logic [15:0]                      dis_data,
   output logic [CHAR_W+$clog2(FONT_H)-1:0] font_addr,
   output logic                             font_mem_en,
   input  logic [7:0]                       font_data,
   output logic [11:0]                      rgb_out,
   output logic                             de_out,
   output logic                             hs_out,
   output logic                             vs_out
);

   localparam int LINE_W = $clog2(FONT_H);
   localparam int PCOL_W = $clog2(GLYPH_W);
   localparam int COL_W  = COORD_W - PCOL_W;
   localparam int ROW_W  = COORD_W - LINE_W;
   localparam int CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int FA_W   = CHAR_W + LINE_W;

   typedef struct packed {
      logic              valid;
      logic              hit;
      logic [PCOL_W-1:0] pcol;
      logic [LINE_W-1:0] line;
   } pipe_t;

   pipe_t             pipe_d [LATENCY];
   pipe_t             pipe_q [LATENCY];
   attr_t             attr_d [2];
   attr_t             attr_q [2];
   sync_t             sync_d [LATENCY+1];
   sync_t             sync_q [LATENCY+1];
   logic [ADDR_W-1:0] dis_addr_d, dis_addr_q;
   logic              dis_mem_en_d, dis_mem_en_q;
   logic [FA_W-1:0]   font_addr_d, font_addr_q;
   logic              font_mem_en_d, font_mem_en_q;
   logic [11:0]       rgb_d, rgb_q;
   logic [CNT_W-1:0]  blink_cnt_d, blink_cnt_q;
   logic              blink_phase_d, blink_phase_q;

   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic              cell_valid;
   logic              px;
   logic [3:0]        irgb;
   logic [11:0]       pal_rgb;

   // NOTE: every signal assigned here gets a value before any condition, so no latch is inferred.
   always_comb begin
      col        = pix_x[COORD_W-1:PCOL_W];
      row        = pix_y[COORD_W-1:LINE_W];
      cell_valid = de_in && (32'(col) < COLS) && (32'(row) < ROWS);

      dis_addr_d   = ADDR_W'(32'(row) * 32'(COLS) + 32'(col));
      dis_mem_en_d = cell_valid;
      pipe_d[0]    = '{valid: cell_valid,
                       hit:   cell_valid && (32'(col) == 32'(cursor_col))
                                         && (32'(row) == 32'(cursor_row)),
                       pcol:  pix_x[PCOL_W-1:0],
                       line:  pix_y[LINE_W-1:0]};
      for (int i = 1; i < LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end

      // Display data returns two edges after the pixel was sampled.
      font_addr_d   = {dis_data[CHAR_MSB:CHAR_LSB], pipe_q[1].line};
      font_mem_en_d = pipe_q[1].valid;
      attr_d[0]     = attr_t'(dis_data[ATTR_MSB:ATTR_LSB]);
      attr_d[1]     = attr_q[0];

      sync_d[0] = '{vs: vs_in, hs: hs_in, de: de_in};
      for (int i = 1; i <= LATENCY; i++) begin
         sync_d[i] = sync_q[i-1];
      end

      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (frame_start) begin
         if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      px = font_data[PCOL_W'(GLYPH_W - 1) - pipe_q[LATENCY-1].pcol];
      if (attr_q[1].blink && blink_phase_q) begin
         px = 1'b0;
      end
      // The underline cursor blinks in step with the attribute blink phase.
      if (pipe_q[LATENCY-1].hit && cursor_en && blink_phase_q &&
          (32'(pipe_q[LATENCY-1].line) >= FONT_H - CURSOR_H)) begin
         px = 1'b1;
      end
      irgb = px ? attr_q[1].fg : {1'b0, attr_q[1].bg};
   end

   txt_palette u_palette (
      .irgb (irgb),
      .rgb  (pal_rgb)
   );

   assign rgb_d = pipe_q[LATENCY-1].valid ? pal_rgb : 12'h000;

   // NOTE: state updates use <= only; the pipeline is small control state, so all of it is reset.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe_q[i] <= '0;
         end
         for (int i = 0; i < 2; i++) begin
            attr_q[i] <= '0;
         end
         for (int i = 0; i <= LATENCY; i++) begin
            sync_q[i] <= '0;
         end
         dis_addr_q    <= '0;
         dis_mem_en_q  <= 1'b0;
         font_addr_q   <= '0;
         font_mem_en_q <= 1'b0;
         rgb_q         <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else begin
         pipe_q        <= pipe_d;
         attr_q        <= attr_d;
         sync_q        <= sync_d;
         dis_addr_q    <= dis_addr_d;
         dis_mem_en_q  <= dis_mem_en_d;
         font_addr_q   <= font_addr_d;
         font_mem_en_q <= font_mem_en_d;
         rgb_q         <= rgb_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   assign dis_addr    = dis_addr_q;
   assign dis_mem_en  = dis_mem_en_q;
   assign font_addr   = font_addr_q;
   assign font_mem_en = font_mem_en_q;
   assign rgb_out     = rgb_q;
   assign de_out      = sync_q[LATENCY].de;
   assign hs_out      = sync_q[LATENCY].hs;
   assign vs_out      = sync_q[LATENCY].vs;

endmodule

// File: tb/tb_txt_attr_renderer.sv
// Randomised and directed bench for txt_attr_renderer against a per-pixel
// reference model driven by the same display and font memory contents.
module tb_txt_attr_renderer;

   localparam int COLS    = 80;
   localparam int ROWS    = 30;
   localparam int FONT_H  = 16;
   localparam int COORD_W = 10;
   localparam int ADDR_W  = 12;
   localparam int BLINK   = 30;
   localparam int MAXC    = 8192;

   logic               clk = 1'b0;
   logic               clr = 1'b1;
   logic [COORD_W-1:0] pix_x = '0;
   logic [COORD_W-1:0] pix_y = '0;
   logic               de_in = 1'b0;
   logic               hs_in = 1'b0;
   logic               vs_in = 1'b0;
   logic               frame_start = 1'b0;
   logic               cursor_en = 1'b0;
   logic [6:0]         cursor_col = '0;
   logic [4:0]         cursor_row = '0;
   logic [ADDR_W-1:0]  dis_addr;
   logic               dis_mem_en;
   logic [15:0]        dis_data = '0;
   logic [11:0]        font_addr;
   logic               font_mem_en;
   logic [7:0]         font_data = '0;
   logic [11:0]        rgb_out;
   logic               de_out;
   logic               hs_out;
   logic               vs_out;

   always #5 clk = ~clk;

   txt_attr_renderer #(
      .COLS(COLS), .ROWS(ROWS), .FONT_H(FONT_H), .COORD_W(COORD_W),
      .ADDR_W(ADDR_W), .BLINK_FRAMES(BLINK)
   ) dut (
      .clk(clk), .clr(clr), .pix_x(pix_x), .pix_y(pix_y), .de_in(de_in),
      .hs_in(hs_in), .vs_in(vs_in), .frame_start(frame_start),
      .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
      .dis_addr(dis_addr), .dis_mem_en(dis_mem_en), .dis_data(dis_data),
      .font_addr(font_addr), .font_mem_en(font_mem_en), .font_data(font_data),
      .rgb_out(rgb_out), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out)
   );

   logic [15:0] dis_mem  [0:4095];
   logic [7:0]  font_mem [0:4095];

   always @(posedge clk) begin
      if (dis_mem_en)  dis_data  <= dis_mem[dis_addr];
      if (font_mem_en) font_data <= font_mem[font_addr];
   end

   typedef struct {
      int x;
      int y;
      bit de;
      bit hs;
      bit vs;
      bit clr;
      bit fs;
      bit cen;
      int ccol;
      int crow;
   } rec_t;

   rec_t hist    [0:MAXC-1];
   bit   phase_b [0:MAXC-1];
   int   n      = 0;
   int   fs_cnt = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, n);
      end
   endtask

   function automatic bit cell_ok(input int m);
      return hist[m].de && (hist[m].x / 8 < COLS) && (hist[m].y / FONT_H < ROWS);
   endfunction

   function automatic int cell_addr(input int m);
      return (hist[m].y / FONT_H) * COLS + hist[m].x / 8;
   endfunction

   function automatic bit rst_in(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         if (i < 0 || hist[i].clr) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [11:0] pal(input logic [3:0] c);
      int lv [3];
      if (c == 4'b0110) return 12'hA50;
      for (int i = 0; i < 3; i++) begin
         lv[i] = (c[2-i] ? 10 : 0) + (c[3] ? 5 : 0);
      end
      return {4'(lv[0]), 4'(lv[1]), 4'(lv[2])};
   endfunction

   function automatic logic [11:0] exp_rgb(input int m, input bit ph, input bit cen);
      int          col, row, line, pc;
      logic [15:0] w;
      logic [7:0]  g;
      bit          p;
      logic [3:0]  c;
      if (!cell_ok(m)) return 12'h000;
      col  = hist[m].x / 8;
      row  = hist[m].y / FONT_H;
      line = hist[m].y % FONT_H;
      pc   = hist[m].x % 8;
      w    = dis_mem[row * COLS + col];
      g    = font_mem[int'(w[7:0]) * FONT_H + line];
      p    = g[7-pc];
      if (w[15] && ph) p = 1'b0;
      if (cen && ph && col == hist[m].ccol && row == hist[m].crow && line >= FONT_H - 2) p = 1'b1;
      c = p ? w[11:8] : {1'b0, w[14:12]};
      return pal(c);
   endfunction

   task automatic do_checks(input int k);
      int m;
      if (hist[k].clr) begin
         check("rst_dis_addr", 32'(dis_addr), 32'd0);
         check("rst_dis_en", 32'(dis_mem_en), 32'd0);
         check("rst_font_addr", 32'(font_addr), 32'd0);
         check("rst_font_en", 32'(font_mem_en), 32'd0);
      end else begin
         check("dis_en", 32'(dis_mem_en), 32'(cell_ok(k)));
         if (cell_ok(k)) check("dis_addr", 32'(dis_addr), 32'(cell_addr(k)));
         m = k - 2;
         if (rst_in(m, k - 1)) begin
            check("font_en_flush", 32'(font_mem_en), 32'd0);
         end else begin
            check("font_en", 32'(font_mem_en), 32'(cell_ok(m)));
            if (cell_ok(m))
               check("font_addr", 32'(font_addr),
                     32'({dis_mem[cell_addr(m)][7:0], 4'(hist[m].y % FONT_H)}));
         end
      end
      m = k - 4;
      if (rst_in(m, k)) begin
         check("rst_rgb", 32'(rgb_out), 32'd0);
         check("rst_syncs", 32'({vs_out, hs_out, de_out}), 32'd0);
      end else begin
         check("rgb", 32'(rgb_out), 32'(exp_rgb(m, phase_b[k], hist[k].cen)));
         check("syncs", 32'({vs_out, hs_out, de_out}),
               32'({hist[m].vs, hist[m].hs, hist[m].de}));
      end
   endtask

   task automatic tick();
      if (n >= MAXC) begin
         $display("FAIL cycle_budget got=%0d exp<%0d", n, MAXC);
         $fatal(1);
      end
      hist[n] = '{x: int'(pix_x), y: int'(pix_y), de: de_in, hs: hs_in, vs: vs_in,
                  clr: clr, fs: frame_start, cen: cursor_en,
                  ccol: int'(cursor_col), crow: int'(cursor_row)};
      phase_b[n] = ((fs_cnt / BLINK) % 2) == 1;
      @(posedge clk);
      if (clr) fs_cnt = 0;
      else if (frame_start) fs_cnt++;
      #1;
      do_checks(n);
      n++;
   endtask

   task automatic idle(input int k);
      de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0; frame_start = 1'b0;
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic drive(input int x, input int y);
      pix_x = COORD_W'(x); pix_y = COORD_W'(y);
      de_in = 1'b1; frame_start = 1'b0;
   endtask

   task automatic probe(input string tag, input int x, input int y, input logic [11:0] exp);
      drive(x, y);
      tick();
      idle(4);
      check(tag, 32'(rgb_out), 32'(exp));
   endtask

   task automatic pulses(input int k);
      de_in = 1'b0;
      for (int i = 0; i < k; i++) begin
         frame_start = 1'b1; tick();
         frame_start = 1'b0; tick();
      end
   endtask

   initial begin
      int x0, yl;
      for (int i = 0; i < 4096; i++) begin
         dis_mem[i]  = 16'($urandom);
         font_mem[i] = 8'($urandom);
      end
      clr = 1'b1;
      idle(3);
      clr = 1'b0;

      for (int seg = 0; seg < 6; seg++) begin
         idle(5);
         cursor_col = 7'($urandom_range(0, 85));
         cursor_row = 5'($urandom_range(0, 31));
         cursor_en  = ($urandom_range(0, 3) != 0);
         x0 = 0; yl = 0;
         for (int k = 0; k < 500; k++) begin
            if (k % 40 == 0) begin
               x0 = $urandom_range(0, 700);
               yl = ($urandom_range(0, 1) == 1) ? int'(cursor_row) * FONT_H + $urandom_range(0, 15)
                                                : $urandom_range(0, 520);
            end
            pix_x       = COORD_W'(x0 + k % 40);
            pix_y       = COORD_W'(yl);
            de_in       = ($urandom_range(0, 15) != 0);
            hs_in       = 1'($urandom);
            vs_in       = 1'($urandom);
            frame_start = ($urandom_range(0, 15) == 0);
            clr         = (seg == 2 && k >= 200 && k < 203);
            tick();
         end
         clr = 1'b0;
      end

      cursor_en = 1'b0;
      clr = 1'b1;
      idle(2);
      clr = 1'b0;
      dis_mem[162]  = 16'h1C41;
      dis_mem[165]  = 16'h1A41;
      dis_mem[166]  = 16'h9C41;
      font_mem[1043] = 8'h18;
      font_mem[1052] = 8'h3C;
      font_mem[1053] = 8'h00;
      font_mem[1054] = 8'h00;
      font_mem[1055] = 8'h00;

      drive(17, 35);
      tick();
      check("addr_162", 32'(dis_addr), 32'd162);
      check("addr_en", 32'(dis_mem_en), 32'd1);
      idle(2);
      check("font_addr_413", 32'(font_addr), 32'h413);
      check("font_addr_en", 32'(font_mem_en), 32'd1);
      idle(3);

      probe("colour_col3", 19, 35, 12'hF55);
      probe("colour_col0", 16, 35, 12'h00A);

      pulses(BLINK);
      probe("blink_lit_bg", 51, 35, 12'h00A);
      probe("noblink_attr", 19, 35, 12'hF55);

      cursor_col = 7'd5; cursor_row = 5'd2; cursor_en = 1'b1;
      for (int ln = 12; ln < 16; ln++) begin
         for (int c = 0; c < 8; c++) begin
            drive(40 + c, 32 + ln);
            tick();
         end
      end
      idle(4);
      probe("cursor_l14", 40, 46, 12'h5F5);
      probe("cursor_l15c7", 47, 47, 12'h5F5);
      probe("cursor_l12c0", 40, 44, 12'h00A);
      probe("cursor_l12c2", 42, 44, 12'h5F5);

      pulses(BLINK);
      probe("blink_off", 51, 35, 12'hF55);
      probe("cursor_off", 40, 46, 12'h00A);

      drive(640, 35);
      hs_in = 1'b1; vs_in = 1'b1;
      tick();
      check("bound_dis_en", 32'(dis_mem_en), 32'd0);
      idle(4);
      check("bound_rgb", 32'(rgb_out), 32'd0);
      check("bound_syncs", 32'({vs_out, hs_out, de_out}), 32'h7);
      idle(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
